sha_msg_padder: RTL and testbench

- Host-side transmitter for the SHA-256 core's byte-input interface.
- Takes a message length command and a raw message byte stream.
- Emits the fully padded SHA-256 block stream on the core's write interface: data, write_enable, first_block and last_block.
- Generates the 0x80 marker, zero fill and 64-bit big-endian bit-length field in hardware, replacing hand-built padding in stimulus and firmware.

---
 rtl/sha_msg_padder_if.sv | 44 ++++
 rtl/sha_msg_padder.sv | 176 +++++++++++++++++
 tb/tb_sha_msg_padder.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/sha_msg_padder_if.sv
`default_nettype none
// ============================================================================
// sha_msg_padder_if : command, byte-stream and core-write bundle for the padder
// Optional: SHA_PAD_LEN_CHECK_EN adds the len_err status signal
// Revision: 1.0
// ============================================================================
interface sha_msg_padder_if #(
    parameter int LEN_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic [7:0]       s_data;
    logic             s_valid;
    logic             s_ready;
    logic             s_last;
    logic             core_busy;
    logic [7:0]       data;
    logic             write_enable;
    logic             first_block;
    logic             last_block;
    logic             done;
`ifdef SHA_PAD_LEN_CHECK_EN
    logic             len_err;
`endif

    // master = padder side, slave = host/core side
    modport master (
        input  cmd_valid, cmd_len, s_data, s_valid, s_last, core_busy,
        output cmd_ready, s_ready, data, write_enable, first_block, last_block, done
`ifdef SHA_PAD_LEN_CHECK_EN
        , output len_err
`endif
    );

    modport slave (
        output cmd_valid, cmd_len, s_data, s_valid, s_last, core_busy,
        input  cmd_ready, s_ready, data, write_enable, first_block, last_block, done
`ifdef SHA_PAD_LEN_CHECK_EN
        , input len_err
`endif
    );
endinterface
`default_nettype wire

// File: rtl/sha_msg_padder.sv
`default_nettype none
// ============================================================================
// sha_msg_padder : streams a message as fully padded SHA-256 64-byte blocks
// Optional: SHA_PAD_LEN_CHECK_EN adds a sticky s_last/length mismatch flag
// Revision: 1.0
// ============================================================================
module sha_msg_padder #(
    parameter int LEN_W      = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    sha_msg_padder_if.master bus
);
    localparam int         BLK_W    = LEN_W - 5;
    localparam int         POS_W    = LEN_W + 1;
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_SEND = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t           state_q;
    logic [LEN_W-1:0] len_q;
    logic [BLK_W-1:0] blk_q;
    logic [BLK_W-1:0] last_blk_q;
    logic [5:0]       idx_q;
    logic [3:0]       gap_q;
    logic             cmd_ready_q;
    logic             we_q;
    logic             first_q;
    logic             last_q;
    logic             done_q;
    logic [7:0]       data_q;

    logic [POS_W-1:0] pos_d;
    logic [BLK_W-1:0] last_blk_d;
    logic [63:0]      bitlen_d;
    logic [7:0]       byte_d;
    logic             is_msg_d;
    logic             is_mark_d;
    logic             is_final_d;
    logic             is_len_d;
    logic             emit_d;
    logic             accept_d;

    assign pos_d      = {blk_q, idx_q};
    assign is_msg_d   = pos_d < {1'b0, len_q};
    assign is_mark_d  = pos_d == {1'b0, len_q};
    assign is_final_d = blk_q == last_blk_q;
    assign is_len_d   = is_final_d && (idx_q[5:3] == 3'b111);
    assign bitlen_d   = {{(61-LEN_W){1'b0}}, len_q, 3'b000};
    assign last_blk_d = BLK_W'(({1'b0, bus.cmd_len} + POS_W'(8)) >> 6);

    // Length field occupies bytes 56..63 of the final block, MSB first
    always_comb begin
        byte_d = 8'h00;
        if (is_msg_d) begin
            byte_d = bus.s_data;
        end else if (is_mark_d) begin
            byte_d = 8'h80;
        end else if (is_len_d) begin
            byte_d = bitlen_d[{~idx_q[2:0], 3'b000} +: 8];
        end
    end

    assign bus.s_ready = (state_q == S_SEND) && is_msg_d;
    assign accept_d    = bus.s_ready && bus.s_valid;
    assign emit_d      = (state_q == S_SEND) && (!is_msg_d || bus.s_valid);

`ifdef SHA_PAD_LEN_CHECK_EN
    logic len_err_q;
    assign bus.len_err = len_err_q;
`else
    logic unused_s_last;
    assign unused_s_last = bus.s_last;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            blk_q       <= '0;
            last_blk_q  <= '0;
            idx_q       <= 6'd0;
            gap_q       <= 4'd0;
            cmd_ready_q <= 1'b0;
            we_q        <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            data_q      <= 8'h00;
`ifdef SHA_PAD_LEN_CHECK_EN
            len_err_q   <= 1'b0;
`endif
        end else begin
            we_q    <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (bus.cmd_valid && cmd_ready_q) begin
                        len_q       <= bus.cmd_len;
                        last_blk_q  <= last_blk_d;
                        blk_q       <= '0;
                        idx_q       <= 6'd0;
                        gap_q       <= 4'd0;
                        cmd_ready_q <= 1'b0;
                        state_q     <= S_WAIT;
`ifdef SHA_PAD_LEN_CHECK_EN
                        len_err_q   <= 1'b0;
`endif
                    end
                end
                S_WAIT: begin
                    if (!bus.core_busy) begin
                        state_q <= S_SEND;
                    end
                end
                S_SEND: begin
                    // A starved message byte leaves idx and data untouched
                    if (emit_d) begin
                        we_q    <= 1'b1;
                        data_q  <= byte_d;
                        first_q <= (idx_q == 6'd0) && (blk_q == '0);
                        last_q  <= (idx_q == 6'd0) && is_final_d;
                        idx_q   <= idx_q + 6'd1;
                        if (idx_q == 6'd63) begin
                            gap_q   <= 4'd0;
                            state_q <= S_GAP;
                        end
                    end
`ifdef SHA_PAD_LEN_CHECK_EN
                    if (accept_d &&
                        (bus.s_last != (pos_d == ({1'b0, len_q} - POS_W'(1))))) begin
                        len_err_q <= 1'b1;
                    end
`endif
                end
                S_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        if (is_final_d) begin
                            done_q      <= 1'b1;
                            cmd_ready_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            blk_q   <= blk_q + BLK_W'(1);
                            state_q <= S_WAIT;
                        end
                    end else begin
                        gap_q <= gap_q + 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifndef SHA_PAD_LEN_CHECK_EN
    logic unused_accept;
    assign unused_accept = accept_d;
`endif

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.data         = data_q;
    assign bus.write_enable = we_q;
    assign bus.first_block  = first_q;
    assign bus.last_block   = last_q;
    assign bus.done         = done_q;
endmodule
`default_nettype wire

// File: tb/tb_sha_msg_padder.sv
`default_nettype none
// ============================================================================
// tb_sha_msg_padder : directed vector bench for sha_msg_padder
// Revision: 1.0
// ============================================================================
module tb_sha_msg_padder;
    localparam int LEN_W = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sha_msg_padder_if #(.LEN_W(LEN_W)) bus ();

    sha_msg_padder #(
        .LEN_W      (LEN_W),
        .GAP_CYCLES (1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int         len;
        logic [7:0] base;
        bit         incr;
        int         stall_pos;
        int         stall_cyc;
        int         busy_cyc;
        int         exp_blocks;
        logic [7:0] exp_b62;
        logic [7:0] exp_b63;
        bit         noisy;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] msg_byte(input vec_t v, input int k);
        return v.incr ? 8'(int'(v.base) + k) : v.base;
    endfunction

    // Reference padding: message, 0x80, zeros to 56 mod 64, 64-bit bit length
    task automatic build_exp(input vec_t v);
        logic [63:0] bl;
        exp_q.delete();
        for (int k = 0; k < v.len; k++) exp_q.push_back(msg_byte(v, k));
        exp_q.push_back(8'h80);
        while ((exp_q.size() % 64) != 56) exp_q.push_back(8'h00);
        bl = 64'(v.len) * 64'd8;
        for (int j = 7; j >= 0; j--) exp_q.push_back(bl[8*j +: 8]);
    endtask

    task automatic run_vec(input vec_t v, input string tag, input int rst_at);
        int  k = 0, stall_done = 0, busy_left = 0, busy_fall = 0, blk1_cyc = 0;
        int  span_start = 0, span_end = 0, done_cyc = 0, last_cyc = 0;
        int  first_cnt = 0, last_cnt = 0, first_pos = -1, last_pos = -1, stray = 0;
        int  t = 0, nbad = 0;
        int  total = v.exp_blocks * 64;
        bit  done_seen = 0, busy_started = 0, aborted = 0, want, hold;
        logic ready_at_done = 1'b0;

        build_exp(v);
        got_q.delete();

        @(negedge clk);
        while (!bus.cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({tag, " cmd_ready before command"}, 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 16'(v.len);

        for (int c = 0; c < 3000 && !done_seen && !aborted; c++) begin
            @(negedge clk);
            if (bus.write_enable) begin
                if (got_q.size() == 0)  span_start = cyc;
                if (got_q.size() == 63) span_end   = cyc;
                if (got_q.size() == 64) blk1_cyc   = cyc;
                if (bus.first_block) begin first_cnt++; first_pos = got_q.size(); end
                if (bus.last_block)  begin last_cnt++;  last_pos  = got_q.size(); end
                got_q.push_back(bus.data);
                last_cyc = cyc;
            end else if (bus.first_block || bus.last_block) begin
                stray++;
            end
            if (bus.done) begin
                done_seen     = 1'b1;
                done_cyc      = cyc;
                ready_at_done = bus.cmd_ready;
            end

            if (rst_at >= 0 && got_q.size() == rst_at) begin
                aborted = 1'b1;
                reset_n = 1'b0;
                #1;
                check({tag, " outputs in reset"},
                      64'({bus.cmd_ready, bus.s_ready, bus.write_enable, bus.first_block,
                           bus.last_block, bus.done, bus.data}), 64'd0);
                bus.cmd_valid = 1'b0;
                bus.s_valid   = 1'b0;
                bus.core_busy = 1'b0;
                @(negedge clk);
                @(negedge clk);
                reset_n = 1'b1;
                @(negedge clk);
                check({tag, " cmd_ready after release"}, 64'(bus.cmd_ready), 64'd1);
            end else begin
                bus.cmd_valid = v.noisy && (got_q.size() < total);
                bus.cmd_len   = 16'd5;

                want = (k < v.len);
                hold = want && (k == v.stall_pos) && (stall_done < v.stall_cyc);
                if (hold && bus.s_ready) stall_done++;
                bus.s_valid = want && !hold;
                bus.s_data  = want ? msg_byte(v, k) : 8'h00;
                if (bus.s_valid && bus.s_ready) k++;

                if (v.busy_cyc > 0 && !busy_started && got_q.size() == 64) begin
                    busy_started  = 1'b1;
                    busy_left     = v.busy_cyc;
                    bus.core_busy = 1'b1;
                end else if (busy_left > 0) begin
                    busy_left--;
                    if (busy_left == 0) begin
                        bus.core_busy = 1'b0;
                        busy_fall     = cyc;
                    end
                end
            end
        end
        bus.cmd_valid = 1'b0;
        bus.s_valid   = 1'b0;
        bus.core_busy = 1'b0;
        if (aborted) return;

        check({tag, " done seen"}, 64'(done_seen), 64'd1);
        check({tag, " byte count"}, 64'(got_q.size()), 64'(total));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) nbad++;
        check({tag, " stream bytes wrong"}, 64'(nbad), 64'd0);
        if (got_q.size() >= 2) begin
            check({tag, " length byte 62"}, 64'(got_q[got_q.size()-2]), 64'(v.exp_b62));
            check({tag, " length byte 63"}, 64'(got_q[got_q.size()-1]), 64'(v.exp_b63));
        end
        check({tag, " first_block count"}, 64'(first_cnt), 64'd1);
        check({tag, " first_block pos"}, 64'(first_pos), 64'd0);
        check({tag, " last_block count"}, 64'(last_cnt), 64'd1);
        check({tag, " last_block pos"}, 64'(last_pos), 64'((v.exp_blocks - 1) * 64));
        check({tag, " flags without write_enable"}, 64'(stray), 64'd0);
        check({tag, " done after last byte"}, 64'(done_cyc - last_cyc), 64'd1);
        check({tag, " cmd_ready with done"}, 64'(ready_at_done), 64'd1);
        if (v.stall_cyc > 0)
            check({tag, " block0 span cycles"}, 64'(span_end - span_start + 1),
                  64'(64 + v.stall_cyc));
        if (v.busy_cyc > 0)
            check({tag, " block1 start after busy"}, 64'(blk1_cyc - busy_fall), 64'd2);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        bus.s_data    = 8'h00;
        bus.s_valid   = 1'b0;
        bus.s_last    = 1'b0;
        bus.core_busy = 1'b0;

        //          len  base   inc stall sc busy blk  b62    b63    noisy
        vecs[0] = '{56,  8'h30, 0,  -1,   0, 0,   2,   8'h01, 8'hC0, 0};
        vecs[1] = '{120, 8'h30, 0,  -1,   0, 0,   3,   8'h03, 8'hC0, 1};
        vecs[2] = '{0,   8'h30, 0,  -1,   0, 0,   1,   8'h00, 8'h00, 0};
        vecs[3] = '{55,  8'h41, 1,  -1,   0, 0,   1,   8'h01, 8'hB8, 0};
        vecs[4] = '{64,  8'h10, 1,  10,   3, 5,   2,   8'h02, 8'h00, 0};
        vecs[5] = '{100, 8'hA5, 1,  -1,   0, 0,   2,   8'h03, 8'h20, 1};

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset cmd_ready", 64'(bus.cmd_ready), 64'd0);
        check("reset outputs",
              64'({bus.write_enable, bus.first_block, bus.last_block, bus.done, bus.data}),
              64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("cmd_ready first cycle after reset", 64'(bus.cmd_ready), 64'd1);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("v%0d", i), -1);

        run_vec(vecs[0], "midreset", 30);
        run_vec(vecs[0], "after_reset", -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
